tile_spawn_writer: RTL and testbench

Sits directly downstream of new_block_generator. After each accepted move, the board controller pulses spawn_req. This block then:
- qualifies the generator's done/out/out_preset stream against the live occupancy mask;
- falls back to a deterministic scan if the random picks keep landing on occupied cells;
- issues one write of the new tile (exponent 1 = "2", exponent 2 = "4") into the board register file.
It also drives the occupancy mask that feeds the generator's `in` port.

---
 rtl/tile_pkg.sv | 29 ++
 rtl/first_zero16.sv | 23 ++
 rtl/tile_spawn_writer.sv | 130 +++++++++++++
 tb/tb_tile_spawn_writer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared types and constants for the tile spawn writer and its helpers.
package tile_pkg;

    // Tile exponents as stored in the board register file.
    localparam logic [3:0] TILE_EMPTY = 4'd0;
    localparam logic [3:0] TILE_TWO   = 4'd1;
    localparam logic [3:0] TILE_FOUR  = 4'd2;

    // Board geometry: a 4x4 board, one occupancy bit per cell.
    localparam int N_CELLS = 16;

    // Occupancy mask of a board with no empty cell left.
    localparam logic [N_CELLS-1:0] BOARD_FULL = {N_CELLS{1'b1}};

    // Spawn controller states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        WAIT   = 3'd2,
        SCAN   = 3'd3,
        WRITE  = 3'd4
    } spawn_state_t;

    // Map the generator's preset bit onto the tile exponent to write.
    function automatic logic [3:0] tile_code(input logic preset);
        return preset ? TILE_FOUR : TILE_TWO;
    endfunction

endpackage

// File: rtl/first_zero16.sv
// Combinational priority encoder: index of the lowest-numbered zero bit
// in a 16-bit vector, with a flag telling whether any zero exists.
module first_zero16
    import tile_pkg::*;
(
    input  logic [N_CELLS-1:0] vec,
    output logic [3:0]         idx,
    output logic               found
);

    // Walk from the top bit down so the lowest zero is the last one written.
    always_comb begin
        idx   = 4'd0;
        found = 1'b0;
        for (int i = N_CELLS - 1; i >= 0; i--) begin
            if (!vec[i]) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_spawn_writer.sv
// Places one new tile on the board after every accepted move. Random picks
// from the upstream generator are double-checked against the live occupancy
// mask; if they keep landing on occupied cells the lowest empty cell is used
// instead. Exactly one board write is issued per accepted request.
module tile_spawn_writer
    import tile_pkg::*;
#(
    parameter int MAX_TRIES = 32,
    parameter int TRY_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                spawn_req,
    input  logic [N_CELLS-1:0]  occ,
    output logic [N_CELLS-1:0]  occ_to_gen,
    input  logic                gen_done,
    input  logic [3:0]          gen_cell,
    input  logic                gen_preset,
    output logic                wr_en,
    output logic [3:0]          wr_addr,
    output logic [3:0]          wr_data,
    output logic                busy,
    output logic                spawn_done,
    output logic                spawn_fail,
    output logic                used_scan
);

    // Last try-counter value spent in WAIT before falling back to the scan.
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    spawn_state_t     state;
    logic [TRY_W-1:0] try_cnt;

    logic [3:0]       scan_idx;
    logic             scan_found;
    logic             gen_hit;
    logic [3:0]       gen_tile;

    // The generator sees the same mask we qualify against.
    assign occ_to_gen = occ;

    // Busy is a pure state decode so the board controller sees it immediately.
    assign busy = (state != IDLE);

    // A generator pick is only trusted if the cell is still empty right now.
    assign gen_hit  = gen_done && !occ[gen_cell];
    assign gen_tile = tile_code(gen_preset);

    first_zero16 u_first_zero (
        .vec   (occ),
        .idx   (scan_idx),
        .found (scan_found)
    );

    // Spawn sequencing and all registered outputs; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            try_cnt    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= 4'd0;
            wr_data    <= 4'd0;
            spawn_done <= 1'b0;
            spawn_fail <= 1'b0;
            used_scan  <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            spawn_done <= 1'b0;
            spawn_fail <= 1'b0;

            case (state)
                IDLE: begin
                    if (spawn_req) begin
                        if (occ == BOARD_FULL) begin
                            spawn_fail <= 1'b1;
                        end else begin
                            state     <= SETTLE;
                            try_cnt   <= '0;
                            used_scan <= 1'b0;
                        end
                    end
                end

                // The generator's done here still reflects the pre-write mask.
                SETTLE: begin
                    state <= WAIT;
                end

                WAIT: begin
                    if (gen_hit) begin
                        wr_addr    <= gen_cell;
                        wr_data    <= gen_tile;
                        wr_en      <= 1'b1;
                        spawn_done <= 1'b1;
                        state      <= WRITE;
                    end else if (try_cnt == LAST_TRY) begin
                        state <= SCAN;
                    end else begin
                        try_cnt <= try_cnt + TRY_W'(1);
                    end
                end

                // Deterministic fallback: lowest empty cell, preset sampled now.
                SCAN: begin
                    used_scan <= 1'b1;
                    if (scan_found) begin
                        wr_addr    <= scan_idx;
                        wr_data    <= gen_tile;
                        wr_en      <= 1'b1;
                        spawn_done <= 1'b1;
                        state      <= WRITE;
                    end else begin
                        spawn_fail <= 1'b1;
                        state      <= IDLE;
                    end
                end

                // Strobe is already on the outputs; just return to IDLE.
                WRITE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_spawn_writer.sv
// Self-checking bench for tile_spawn_writer: directed scenarios plus
// randomized transactions checked against a cycle-level outcome model.
module tb_tile_spawn_writer;

    localparam int MAX_TRIES = 32;
    localparam int TRY_W     = 8;
    localparam int LEN       = MAX_TRIES + 8;

    logic        clk;
    logic        rst;
    logic        spawn_req;
    logic [15:0] occ;
    logic [15:0] occ_to_gen;
    logic        gen_done;
    logic [3:0]  gen_cell;
    logic        gen_preset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        busy;
    logic        spawn_done;
    logic        spawn_fail;
    logic        used_scan;

    tile_spawn_writer #(
        .MAX_TRIES (MAX_TRIES),
        .TRY_W     (TRY_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spawn_req  (spawn_req),
        .occ        (occ),
        .occ_to_gen (occ_to_gen),
        .gen_done   (gen_done),
        .gen_cell   (gen_cell),
        .gen_preset (gen_preset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .spawn_done (spawn_done),
        .spawn_fail (spawn_fail),
        .used_scan  (used_scan)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors_applied = 0;
    int miscompares     = 0;

    // Per-transaction stimulus, indexed by cycle relative to the request.
    logic        gd_seq    [LEN];
    logic [3:0]  gc_seq    [LEN];
    logic        gp_seq    [LEN];
    logic        extra_req [LEN];
    logic [15:0] occ_val;

    // Model of the architecturally visible registers between transactions.
    logic [3:0]  model_addr;
    logic [3:0]  model_data;
    logic        model_scan;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lowestZero(input logic [15:0] m);
        for (int b = 0; b < 16; b++) begin
            if (!m[b]) return b;
        end
        return -1;
    endfunction

    // Outcome of one request from the rules: full board fails at once; otherwise
    // the first valid pick in the MAX_TRIES wait cycles wins, else the scan.
    task automatic computeExpected(output int e_wr, output int e_cycle, output int e_fail,
                                   output logic [3:0] e_addr, output logic [3:0] e_data,
                                   output logic e_scan);
        e_wr    = 0;
        e_cycle = -1;
        e_fail  = 0;
        e_addr  = model_addr;
        e_data  = model_data;
        e_scan  = model_scan;
        if (occ_val == 16'hFFFF) begin
            e_fail = 1;
            return;
        end
        for (int k = 0; k < MAX_TRIES; k++) begin
            if (gd_seq[k + 2] && !occ_val[gc_seq[k + 2]]) begin
                e_wr    = 1;
                e_cycle = k + 3;
                e_addr  = gc_seq[k + 2];
                e_data  = gp_seq[k + 2] ? 4'd2 : 4'd1;
                e_scan  = 1'b0;
                return;
            end
        end
        e_wr    = 1;
        e_cycle = MAX_TRIES + 3;
        e_addr  = 4'(lowestZero(occ_val));
        e_data  = gp_seq[MAX_TRIES + 2] ? 4'd2 : 4'd1;
        e_scan  = 1'b1;
    endtask

    // Run one request over a fixed window and compare against the model.
    task automatic applyStimulus(input string tag, input bit random_extra);
        int e_wr, e_cycle, e_fail;
        logic [3:0] e_addr, e_data;
        logic e_scan;
        int wr_count, done_count, fail_count, done_skew, wr_cycle, fail_cycle;
        logic [3:0] seen_addr, seen_data;
        logic busy_at1;

        computeExpected(e_wr, e_cycle, e_fail, e_addr, e_data, e_scan);
        if (random_extra) begin
            for (int i = 0; i < LEN; i++) extra_req[i] = 1'b0;
            if (e_wr == 1) begin
                for (int i = 1; i <= e_cycle; i++) extra_req[i] = ($urandom_range(0, 3) == 0);
            end
        end

        wr_count = 0; done_count = 0; fail_count = 0; done_skew = 0;
        wr_cycle = -1; fail_cycle = -1; seen_addr = 4'd0; seen_data = 4'd0; busy_at1 = 1'b0;

        @(negedge clk);
        occ = occ_val;
        for (int i = 0; i < LEN; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) busy_at1 = busy;
            if (wr_en) begin
                wr_count++;
                wr_cycle  = i;
                seen_addr = wr_addr;
                seen_data = wr_data;
            end
            if (spawn_done) done_count++;
            if (spawn_done !== wr_en) done_skew++;
            if (spawn_fail) begin
                fail_count++;
                fail_cycle = i;
            end
            spawn_req  = (i == 0) || extra_req[i];
            gen_done   = gd_seq[i];
            gen_cell   = gc_seq[i];
            gen_preset = gp_seq[i];
        end
        @(negedge clk);
        spawn_req = 1'b0;
        gen_done  = 1'b0;

        checkOutput({tag, ".busy_at1"},   32'(busy_at1),   32'(e_fail == 0));
        checkOutput({tag, ".wr_count"},   32'(wr_count),   32'(e_wr));
        checkOutput({tag, ".done_count"}, 32'(done_count), 32'(e_wr));
        checkOutput({tag, ".done_skew"},  32'(done_skew),  32'd0);
        checkOutput({tag, ".fail_count"}, 32'(fail_count), 32'(e_fail));
        if (e_wr == 1) begin
            checkOutput({tag, ".wr_cycle"}, 32'(wr_cycle),  32'(e_cycle));
            checkOutput({tag, ".wr_addr"},  32'(seen_addr), 32'(e_addr));
            checkOutput({tag, ".wr_data"},  32'(seen_data), 32'(e_data));
        end
        if (e_fail == 1) begin
            checkOutput({tag, ".fail_cycle"}, 32'(fail_cycle), 32'd1);
        end
        checkOutput({tag, ".used_scan"},  32'(used_scan), 32'(e_scan));
        checkOutput({tag, ".addr_hold"},  32'(wr_addr),   32'(e_addr));
        checkOutput({tag, ".data_hold"},  32'(wr_data),   32'(e_data));
        checkOutput({tag, ".busy_end"},   32'(busy),      32'd0);

        model_addr = e_addr;
        model_data = e_data;
        model_scan = e_scan;
    endtask

    task automatic clearSeq();
        for (int i = 0; i < LEN; i++) begin
            gd_seq[i]    = 1'b0;
            gc_seq[i]    = 4'd0;
            gp_seq[i]    = 1'b0;
            extra_req[i] = 1'b0;
        end
    endtask

    // Reset asserted while waiting: everything drops and no write follows.
    task automatic resetMidWait();
        int late_wr;
        clearSeq();
        @(negedge clk);
        occ = 16'h0000;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 6) begin
                checkOutput("rstwait.busy",    32'(busy),      32'd0);
                checkOutput("rstwait.wr_en",   32'(wr_en),     32'd0);
                checkOutput("rstwait.wr_addr", 32'(wr_addr),   32'd0);
                checkOutput("rstwait.scan",    32'(used_scan), 32'd0);
            end
            spawn_req = (i == 0);
            rst       = (i == 5) ? 1'b0 : 1'b1;
        end
        gen_done = 1'b1;
        gen_cell = 4'd7;
        late_wr  = 0;
        for (int i = 0; i < LEN; i++) begin
            @(negedge clk);
            if (wr_en || spawn_done || spawn_fail) late_wr++;
        end
        gen_done = 1'b0;
        checkOutput("rstwait.no_late_pulse", 32'(late_wr), 32'd0);
        model_addr = 4'd0;
        model_data = 4'd0;
        model_scan = 1'b0;
    endtask

    initial begin
        int mode;
        rst        = 1'b0;
        spawn_req  = 1'b0;
        occ        = 16'h0000;
        gen_done   = 1'b0;
        gen_cell   = 4'd0;
        gen_preset = 1'b0;
        model_addr = 4'd0;
        model_data = 4'd0;
        model_scan = 1'b0;
        clearSeq();

        repeat (3) @(negedge clk);
        spawn_req = 1'b1;
        @(negedge clk);
        checkOutput("reset.busy",       32'(busy),       32'd0);
        checkOutput("reset.wr_en",      32'(wr_en),      32'd0);
        checkOutput("reset.wr_addr",    32'(wr_addr),    32'd0);
        checkOutput("reset.wr_data",    32'(wr_data),    32'd0);
        checkOutput("reset.spawn_done", 32'(spawn_done), 32'd0);
        checkOutput("reset.spawn_fail", 32'(spawn_fail), 32'd0);
        checkOutput("reset.used_scan",  32'(used_scan),  32'd0);
        spawn_req = 1'b0;
        rst       = 1'b1;
        occ       = 16'h0F0F;
        @(negedge clk);
        checkOutput("reset.occ_to_gen", 32'(occ_to_gen), 32'h0F0F);

        resetMidWait();

        // Immediate accept on an empty board.
        clearSeq();
        occ_val = 16'h0000;
        for (int i = 0; i < LEN; i++) begin gd_seq[i] = 1'b1; gc_seq[i] = 4'h5; end
        applyStimulus("fast", 1'b0);

        // Occupied pick rejected, then a valid "4".
        clearSeq();
        occ_val = 16'h0020;
        for (int i = 0; i < LEN; i++) begin
            gd_seq[i] = 1'b1;
            gc_seq[i] = (i < 4) ? 4'h5 : 4'h9;
            gp_seq[i] = (i >= 4);
        end
        applyStimulus("reject", 1'b0);

        // Generator never succeeds: scan picks cell 0.
        clearSeq();
        occ_val = 16'hFFFE;
        for (int i = 0; i < LEN; i++) gp_seq[i] = 1'($urandom_range(0, 1));
        applyStimulus("scan", 1'b0);

        // Full board fails without writing.
        clearSeq();
        occ_val = 16'hFFFF;
        applyStimulus("full", 1'b0);

        // Repeated requests while busy, including the WRITE cycle.
        clearSeq();
        occ_val = 16'h0000;
        for (int i = 6; i < LEN; i++) begin gd_seq[i] = 1'b1; gc_seq[i] = 4'h3; end
        extra_req[1] = 1'b1;
        extra_req[2] = 1'b1;
        extra_req[4] = 1'b1;
        extra_req[7] = 1'b1;
        applyStimulus("busyreq", 1'b0);

        // Randomized transactions across occupancy and generator behaviours.
        for (int t = 0; t < 60; t++) begin
            mode = $urandom_range(0, 5);
            case (mode)
                0:       occ_val = 16'($urandom);
                1:       occ_val = 16'hFFFF;
                2:       occ_val = ~(16'd1 << $urandom_range(0, 15));
                default: occ_val = 16'($urandom) | 16'($urandom);
            endcase
            for (int i = 0; i < LEN; i++) begin
                case (mode)
                    3:       gd_seq[i] = 1'b0;
                    4:       gd_seq[i] = ($urandom_range(0, 15) == 0);
                    default: gd_seq[i] = 1'($urandom_range(0, 1));
                endcase
                gc_seq[i] = 4'($urandom_range(0, 15));
                gp_seq[i] = 1'($urandom_range(0, 1));
            end
            applyStimulus($sformatf("rand%0d", t), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
